apb_v3_master: RTL and testbench

Single-outstanding APB3 master that sits directly upstream of the team's APB SRAM slave. Accepts one read/write command at a time over a simple valid/ready port, runs the APB IDLE→SETUP→ACCESS sequence with wait-state support and an optional access timeout, and returns a one-cycle response pulse carrying read data and an error flag. A compile-time read-latency option supports slaves that register read data one cycle after the completing ACCESS edge.

---
 rtl/apb_v3_master.sv | 150 +++++++++++++++
 tb/tb_apb_v3_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_v3_master.sv
// apb_v3_master: single-outstanding APB3 master.
// Accepts one read/write command over a valid/ready port. It runs the
// IDLE -> SETUP -> ACCESS sequence with wait states and an optional
// access timeout. Each command gets a one-cycle response pulse.
//
// Parameters:
//   RD_LAT  : 0 = P_rdata sampled on the completing ACCESS edge,
//             1 = P_rdata sampled one edge later (RDWAIT state).
//   TIMEOUT : ACCESS cycles without P_ready before abort; 0 disables it.
//
// Ports:
//   P_clk, P_rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/cmd_addr/cmd_wdata    command payload
//   rsp_valid/rsp_rdata/rsp_err     one-cycle response
//   P_addr/P_selx/P_enable/P_write/P_wdata/P_ready/P_rdata  APB3 bus
module apb_v3_master #(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        P_clk,
  input  logic        P_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] P_addr,
  output logic        P_selx,
  output logic        P_enable,
  output logic        P_write,
  output logic [31:0] P_wdata,
  input  logic        P_ready,
  input  logic [31:0] P_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam bit          RD_REG  = (RD_LAT != 0);
  // Unused when TIMEOUT is 0 (the underflowed value is masked by TO_EN).
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] wait_cnt, wait_cnt_nxt;
  logic        sel_nxt, en_nxt, wr_nxt;
  logic        rsp_valid_nxt, rsp_err_nxt;
  logic [31:0] addr_nxt, wdata_nxt, rdata_nxt;

  assign cmd_ready = (state == IDLE);

  // Next-state and next-output logic. The bus outputs are registered, so
  // they are computed here for the state being entered.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    sel_nxt       = P_selx;
    en_nxt        = P_enable;
    wr_nxt        = P_write;
    addr_nxt      = P_addr;
    wdata_nxt     = P_wdata;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = rsp_err;
    rdata_nxt     = rsp_rdata;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = SETUP;
          sel_nxt   = 1'b1;
          addr_nxt  = cmd_addr;
          wr_nxt    = cmd_write;
          wdata_nxt = cmd_wdata;
        end
      end

      SETUP: begin
        state_nxt    = ACCESS;
        en_nxt       = 1'b1;
        wait_cnt_nxt = '0;
      end

      ACCESS: begin
        if (P_ready) begin
          // Ready takes priority over a coincident timeout.
          sel_nxt = 1'b0;
          en_nxt  = 1'b0;
          if (P_write || !RD_REG) begin
            state_nxt     = IDLE;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b0;
            if (!P_write) begin
              rdata_nxt = P_rdata;
            end
          end else begin
            state_nxt = RDWAIT;
          end
        end else if (TO_EN && (wait_cnt == TO_LAST)) begin
          state_nxt     = IDLE;
          sel_nxt       = 1'b0;
          en_nxt        = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rdata_nxt     = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 32'd1;
        end
      end

      RDWAIT: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        rdata_nxt     = P_rdata;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      P_selx    <= 1'b0;
      P_enable  <= 1'b0;
      P_write   <= 1'b0;
      P_addr    <= '0;
      P_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      P_selx    <= sel_nxt;
      P_enable  <= en_nxt;
      P_write   <= wr_nxt;
      P_addr    <= addr_nxt;
      P_wdata   <= wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_v3_master.sv
// tb_apb_v3_master: self-checking bench for apb_v3_master.
// Instance 0: RD_LAT=1, TIMEOUT=4. Instance 1: RD_LAT=0, TIMEOUT=0.
// Table vectors drive single transactions. Expected responses are queued
// per instance and compared when rsp_valid fires. Hand sequences cover
// back-to-back accepts and reset in the middle of a transfer.
`timescale 1ns/1ps
module tb_apb_v3_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_write [2];
  logic [31:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] P_addr    [2];
  logic        P_selx    [2];
  logic        P_enable  [2];
  logic        P_write   [2];
  logic [31:0] P_wdata   [2];
  logic        P_ready   [2];
  logic [31:0] P_rdata   [2];

  apb_v3_master #(.RD_LAT(1), .TIMEOUT(4)) dut0 (
    .P_clk(clk), .P_rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .P_addr(P_addr[0]), .P_selx(P_selx[0]), .P_enable(P_enable[0]),
    .P_write(P_write[0]), .P_wdata(P_wdata[0]),
    .P_ready(P_ready[0]), .P_rdata(P_rdata[0])
  );

  apb_v3_master #(.RD_LAT(0), .TIMEOUT(0)) dut1 (
    .P_clk(clk), .P_rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .P_addr(P_addr[1]), .P_selx(P_selx[1]), .P_enable(P_enable[1]),
    .P_write(P_write[1]), .P_wdata(P_wdata[1]),
    .P_ready(P_ready[1]), .P_rdata(P_rdata[1])
  );

  // d, wr, addr, wdata, waits before ready, prdata, then expected err,
  // ACCESS cycle count and rsp_rdata.
  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    bit          err;
    int          acc;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_rd [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rdlat(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_rsp(input int d);
    exp_t e;
    bit   empty;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_chk++;
      n_err++;
      $display("FAIL rsp_unexpected[%0d]: got rsp_valid=1 expected none (cycle %0d)", d, cyc);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("rsp_cycle[%0d]", d), 32'(cyc), 32'(e.cyc));
      chk($sformatf("rsp_err[%0d]", d), rsp_err[d], e.err);
      chk($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid[0] === 1'b1) check_rsp(0);
    if (rsp_valid[1] === 1'b1) check_rsp(1);
  end

  task automatic run_vec(input vec_t v);
    int   lat;
    int   c0;
    bit   rdw;
    exp_t e;
    int   d;
    d   = v.d;
    rdw = !v.wr && (rdlat(d) == 1) && !v.err;
    lat = 2 + v.acc + (rdw ? 1 : 0);
    @(negedge clk);
    c0 = cyc;
    chk("cmd_ready_idle", cmd_ready[d], 1'b1);
    cmd_valid[d] = 1'b1;
    cmd_write[d] = v.wr;
    cmd_addr[d]  = v.addr;
    cmd_wdata[d] = v.wdata;
    e.cyc = c0 + lat; e.err = v.err; e.rdata = v.rdata;
    push_exp(d, e);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      // Scramble the command inputs so any late latching shows up.
      cmd_valid[d] = 1'b0;
      cmd_addr[d]  = $urandom;
      cmd_wdata[d] = $urandom;
      cmd_write[d] = 1'($urandom);
      P_ready[d]   = 1'b0;
      P_rdata[d]   = ~v.prdata;
      if (k == 1) begin
        chk("setup_selx", P_selx[d], 1'b1);
        chk("setup_enable", P_enable[d], 1'b0);
        chk("setup_cmd_ready", cmd_ready[d], 1'b0);
        chk("setup_addr", P_addr[d], v.addr);
        chk("setup_write", P_write[d], v.wr);
        if (v.wr) chk("setup_wdata", P_wdata[d], v.wdata);
      end else if (k < 2 + v.acc) begin
        chk("access_selx", P_selx[d], 1'b1);
        chk("access_enable", P_enable[d], 1'b1);
        chk("access_addr", P_addr[d], v.addr);
        chk("access_write", P_write[d], v.wr);
        if (k - 2 >= v.waits) begin
          P_ready[d] = 1'b1;
          if (rdlat(d) == 0) P_rdata[d] = v.prdata;
        end
      end else if (k < lat) begin
        chk("rdwait_selx", P_selx[d], 1'b0);
        chk("rdwait_enable", P_enable[d], 1'b0);
        chk("rdwait_cmd_ready", cmd_ready[d], 1'b0);
        P_rdata[d] = v.prdata;
      end else begin
        chk("rsp_selx", P_selx[d], 1'b0);
        chk("rsp_enable", P_enable[d], 1'b0);
        chk("rsp_cmd_ready", cmd_ready[d], 1'b1);
      end
    end
    last_rd[d] = v.rdata;
  endtask

  // cmd_valid held high for three zero-wait writes on instance 0.
  task automatic held_writes();
    logic [31:0] wd [3];
    int          c0;
    exp_t        e;
    wd[0] = 32'h0000_0111; wd[1] = 32'h0000_0222; wd[2] = 32'h0000_0333;
    @(negedge clk);
    c0 = cyc;
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b1;
    cmd_addr[0]  = 32'h40;
    cmd_wdata[0] = wd[0];
    for (int i = 1; i <= 3; i++) begin
      e.cyc = c0 + 3 * i; e.err = 1'b0; e.rdata = last_rd[0];
      push_exp(0, e);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      P_ready[0] = 1'b0;
      case (k % 3)
        1: begin
          chk("held_setup_selx", P_selx[0], 1'b1);
          chk("held_setup_enable", P_enable[0], 1'b0);
          chk("held_wdata", P_wdata[0], wd[k / 3]);
          if (k < 7) begin
            cmd_wdata[0] = wd[k / 3 + 1];
            cmd_addr[0]  = 32'h40 + 32'(k);
          end else begin
            cmd_valid[0] = 1'b0;
          end
        end
        2: begin
          chk("held_access_enable", P_enable[0], 1'b1);
          P_ready[0] = 1'b1;
        end
        default: begin
          chk("held_idle_selx", P_selx[0], 1'b0);
          chk("held_idle_cmd_ready", cmd_ready[0], 1'b1);
        end
      endcase
    end
  endtask

  // Reset asserted during ACCESS of a read on instance 0.
  task automatic reset_mid();
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_write[0] = 1'b0;
    cmd_addr[0]  = 32'h11;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    chk("rstmid_setup_selx", P_selx[0], 1'b1);
    @(negedge clk);
    chk("rstmid_access_enable", P_enable[0], 1'b1);
    P_ready[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_selx", P_selx[0], 1'b0);
    chk("rstmid_enable", P_enable[0], 1'b0);
    chk("rstmid_write", P_write[0], 1'b0);
    chk("rstmid_addr", P_addr[0], 32'h0);
    chk("rstmid_wdata", P_wdata[0], 32'h0);
    chk("rstmid_rsp_valid", rsp_valid[0], 1'b0);
    chk("rstmid_rsp_rdata", rsp_rdata[0], 32'h0);
    chk("rstmid_rsp_err", rsp_err[0], 1'b0);
    chk("rstmid_cmd_ready", cmd_ready[0], 1'b1);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
  endtask

  vec_t tbl  [10];
  vec_t tail [3];

  initial begin
    tbl[0] = '{0, 1'b1, 32'h5,  32'hA,    0, 32'h0,     1'b0, 1, 32'h0};
    tbl[1] = '{0, 1'b0, 32'h5,  32'h0,    0, 32'hA,     1'b0, 1, 32'hA};
    tbl[2] = '{0, 1'b0, 32'h7,  32'h0,    2, 32'h55,    1'b0, 3, 32'h55};
    tbl[3] = '{0, 1'b0, 32'h8,  32'h0,    9, 32'hEE,    1'b1, 4, 32'h0};
    tbl[4] = '{0, 1'b0, 32'h9,  32'h0,    3, 32'h77,    1'b0, 4, 32'h77};
    tbl[5] = '{0, 1'b1, 32'h1,  32'hBEEF, 1, 32'h0,     1'b0, 2, 32'h77};
    tbl[6] = '{0, 1'b1, 32'h2,  32'h9,    5, 32'h0,     1'b1, 4, 32'h0};
    tbl[7] = '{1, 1'b0, 32'h3,  32'h0,    2, 32'h1234,  1'b0, 3, 32'h1234};
    tbl[8] = '{1, 1'b1, 32'h4,  32'h66,   0, 32'h0,     1'b0, 1, 32'h1234};
    tbl[9] = '{1, 1'b0, 32'h6,  32'h0,    7, 32'hCAFE,  1'b0, 8, 32'hCAFE};
    tail[0] = '{0, 1'b1, 32'h20, 32'h5A,  0, 32'h0,     1'b0, 1, 32'h0};
    tail[1] = '{0, 1'b0, 32'h20, 32'h0,   0, 32'h99,    1'b0, 1, 32'h99};
    tail[2] = '{1, 1'b0, 32'h21, 32'h0,   0, 32'h4242,  1'b0, 1, 32'h4242};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_write[d] = 1'b0;
      cmd_addr[d]  = '0;   cmd_wdata[d] = '0;
      P_ready[d]   = 1'b0; P_rdata[d]   = '0;
      last_rd[d]   = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_cmd_ready", cmd_ready[d], 1'b1);
      chk("reset_selx", P_selx[d], 1'b0);
      chk("reset_enable", P_enable[d], 1'b0);
      chk("reset_write", P_write[d], 1'b0);
      chk("reset_addr", P_addr[d], 32'h0);
      chk("reset_wdata", P_wdata[d], 32'h0);
      chk("reset_rsp_valid", rsp_valid[d], 1'b0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      chk("reset_rsp_err", rsp_err[d], 1'b0);
    end

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    held_writes();
    reset_mid();
    for (int i = 0; i < 3; i++) run_vec(tail[i]);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
